// File: rtl/wb_trace_checker.sv
// Writeback trace checker: compares committed (pc, wb_data) pairs against a preloaded table
// in order, counts mismatches and flags a timeout if the program stalls.
//   state   | meaning
//   IDLE    | table writable, waiting for p_i_ce to start
//   RUN     | comparing commits, cycle budget running (paused while p_i_ce=0)
//   PASS    | all DEPTH commits seen, no mismatches
//   FAIL    | all DEPTH commits seen, at least one mismatch
//   TIMEOUT | cycle budget spent before the last commit
module wb_trace_checker #(
   parameter int DWIDTH     = 32,
   parameter int PC_WIDTH   = 32,
   parameter int DEPTH      = 7,
   parameter int MAX_CYCLES = 64,
   parameter int IDX_W      = $clog2(DEPTH + 1),
   parameter int CYC_W      = $clog2(MAX_CYCLES + 1)
) (
   input  logic                p_clk,
   input  logic                p_rst,
   input  logic                p_i_ce,
   input  logic                i_wb_valid,
   input  logic [PC_WIDTH-1:0] i_pc,
   input  logic [DWIDTH-1:0]   i_wb_data,
   input  logic                i_exp_we,
   input  logic [IDX_W-1:0]    i_exp_addr,
   input  logic [PC_WIDTH-1:0] i_exp_pc,
   input  logic [DWIDTH-1:0]   i_exp_data,
   output logic [2:0]          o_state,
   output logic                o_done,
   output logic                o_pass,
   output logic [IDX_W-1:0]    o_commit_cnt,
   output logic [IDX_W-1:0]    o_err_cnt,
   output logic [IDX_W-1:0]    o_first_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RUN     = 3'd1;
   localparam logic [2:0] S_PASS    = 3'd2;
   localparam logic [2:0] S_FAIL    = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PC_WIDTH-1:0] exp_pc   [DEPTH];
   logic [DWIDTH-1:0]   exp_data [DEPTH];

   logic [2:0]       state, state_n;
   logic [IDX_W-1:0] commit_cnt, commit_n;
   logic [IDX_W-1:0] err_cnt, err_n;
   logic [IDX_W-1:0] first_err, first_n;
   logic [CYC_W-1:0] cyc_cnt, cyc_n;
   logic [AW-1:0]    rd_idx;
   logic             mismatch;

   // Table is deliberately outside the reset domain so it survives reset between runs.
   always_ff @(posedge p_clk) begin
      if (state == S_IDLE && i_exp_we && i_exp_addr < IDX_W'(DEPTH)) begin
         exp_pc[i_exp_addr[AW-1:0]]   <= i_exp_pc;
         exp_data[i_exp_addr[AW-1:0]] <= i_exp_data;
      end
   end

   assign rd_idx   = commit_cnt[AW-1:0];
   assign mismatch = (i_pc != exp_pc[rd_idx]) || (i_wb_data != exp_data[rd_idx]);

   always_comb begin
      state_n  = state;
      commit_n = commit_cnt;
      err_n    = err_cnt;
      first_n  = first_err;
      cyc_n    = cyc_cnt;
      case (state)
         S_IDLE: begin
            if (p_i_ce) begin
               state_n  = S_RUN;
               commit_n = '0;
               err_n    = '0;
               first_n  = '0;
               cyc_n    = '0;
            end
         end
         S_RUN: begin
            if (p_i_ce) begin
               cyc_n = cyc_cnt + 1'b1;
               if (i_wb_valid) begin
                  commit_n = commit_cnt + 1'b1;
                  if (mismatch) begin
                     err_n = err_cnt + 1'b1;
                     if (err_cnt == '0) first_n = commit_cnt;
                  end
               end
               // Completion is tested first so a last commit on the timeout edge still passes.
               if (i_wb_valid && commit_n == IDX_W'(DEPTH))
                  state_n = (err_n == '0) ? S_PASS : S_FAIL;
               else if (cyc_n == CYC_W'(MAX_CYCLES))
                  state_n = S_TIMEOUT;
            end
         end
         S_PASS, S_FAIL, S_TIMEOUT: begin
            if (!p_i_ce) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge p_clk or posedge p_rst) begin
      if (p_rst) begin
         state      <= S_IDLE;
         commit_cnt <= '0;
         err_cnt    <= '0;
         first_err  <= '0;
         cyc_cnt    <= '0;
      end else begin
         state      <= state_n;
         commit_cnt <= commit_n;
         err_cnt    <= err_n;
         first_err  <= first_n;
         cyc_cnt    <= cyc_n;
      end
   end

   assign o_state      = state;
   assign o_done       = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
   assign o_pass       = (state == S_PASS);
   assign o_commit_cnt = commit_cnt;
   assign o_err_cnt    = err_cnt;
   assign o_first_err  = first_err;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: each run pushes its expected final result,
// a monitor pops and compares when o_done rises.
module tb_wb_trace_checker;

   localparam int DW = 32, PW = 32, DEPTH = 7, MAXC = 64, IDX_W = 3;

   logic             p_clk = 1'b0;
   logic             p_rst = 1'b1;
   logic             p_i_ce = 1'b0;
   logic             i_wb_valid = 1'b0;
   logic [PW-1:0]    i_pc = '0;
   logic [DW-1:0]    i_wb_data = '0;
   logic             i_exp_we = 1'b0;
   logic [IDX_W-1:0] i_exp_addr = '0;
   logic [PW-1:0]    i_exp_pc = '0;
   logic [DW-1:0]    i_exp_data = '0;
   logic [2:0]       o_state;
   logic             o_done, o_pass;
   logic [IDX_W-1:0] o_commit_cnt, o_err_cnt, o_first_err;

   wb_trace_checker #(.DWIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
      .p_clk(p_clk), .p_rst(p_rst), .p_i_ce(p_i_ce), .i_wb_valid(i_wb_valid),
      .i_pc(i_pc), .i_wb_data(i_wb_data), .i_exp_we(i_exp_we), .i_exp_addr(i_exp_addr),
      .i_exp_pc(i_exp_pc), .i_exp_data(i_exp_data), .o_state(o_state), .o_done(o_done),
      .o_pass(o_pass), .o_commit_cnt(o_commit_cnt), .o_err_cnt(o_err_cnt),
      .o_first_err(o_first_err)
   );

   always #5 p_clk = ~p_clk;

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] commits;
      logic [2:0] errs;
      logic [2:0] first;
      logic       pass;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic done_q  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the final result whenever the checker reports done.
   initial begin
      exp_t e;
      forever begin
         @(negedge p_clk);
         if (o_done && !done_q) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("state",      int'(o_state),      int'(e.st));
               check("commit_cnt", int'(o_commit_cnt), int'(e.commits));
               check("err_cnt",    int'(o_err_cnt),    int'(e.errs));
               check("first_err",  int'(o_first_err),  int'(e.first));
               check("pass",       int'(o_pass),       int'(e.pass));
            end
         end
         done_q = o_done;
      end
   end

   task automatic step();
      @(posedge p_clk);
      #1;
   endtask

   task automatic expect_result(input int st, input int c, input int e, input int f, input int p);
      exp_t x;
      x.st = 3'(st); x.commits = 3'(c); x.errs = 3'(e); x.first = 3'(f); x.pass = 1'(p);
      sb_q.push_back(x);
   endtask

   task automatic commit(input int idx, input logic [PW-1:0] pc, input logic [DW-1:0] data);
      i_wb_valid = 1'b1;
      i_pc       = pc;
      i_wb_data  = data;
      step();
      i_wb_valid = 1'b0;
   endtask

   // Matching commits idx lo..hi, with optional corruption of one data and one pc.
   task automatic commits(input int lo, input int hi, input int bad_data, input int bad_pc);
      for (int i = lo; i <= hi; i++)
         commit(i, (i == bad_pc) ? 32'd8 : 32'(4 * i), (i == bad_data) ? 32'd99 : 32'(10 + i));
   endtask

   task automatic start();
      p_i_ce = 1'b1;
      step();
   endtask

   task automatic finish_run();
      p_i_ce = 1'b0;
      step();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         step();
         n++;
      end
      check("done_reached", int'(o_done), 1);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge p_clk);
      #1;
      check("rst_state",  int'(o_state),      0);
      check("rst_done",   int'(o_done),       0);
      check("rst_pass",   int'(o_pass),       0);
      check("rst_commit", int'(o_commit_cnt), 0);
      check("rst_err",    int'(o_err_cnt),    0);
      check("rst_first",  int'(o_first_err),  0);
      p_rst = 1'b0;
      step();

      for (int i = 0; i < DEPTH; i++) begin
         i_exp_we   = 1'b1;
         i_exp_addr = 3'(i);
         i_exp_pc   = 32'(4 * i);
         i_exp_data = 32'(10 + i);
         step();
      end
      i_exp_we = 1'b0;

      // 1: all commits match
      expect_result(2, 7, 0, 0, 1);
      start();
      commits(0, 6, -1, -1);
      wait_done(10);
      finish_run();

      // 2: data error on commit 3, pc error on commit 5
      expect_result(3, 7, 2, 3, 0);
      start();
      commits(0, 6, 3, 5);
      wait_done(10);
      finish_run();

      // 3: only four commits, expect timeout on the 64th RUN cycle
      expect_result(4, 4, 0, 0, 0);
      start();
      commits(0, 3, -1, -1);
      n = 4;
      while (!o_done && n < 80) begin
         step();
         n++;
      end
      check("timeout_cycle", n, 64);
      finish_run();

      // 4: pause with valid commits and a table write, then resume
      expect_result(2, 7, 0, 0, 1);
      start();
      commits(0, 2, -1, -1);
      p_i_ce     = 1'b0;
      i_wb_valid = 1'b1;
      i_pc       = 32'h55;
      i_wb_data  = 32'h66;
      i_exp_we   = 1'b1;
      i_exp_addr = 3'd4;
      i_exp_pc   = 32'h77;
      i_exp_data = 32'h88;
      repeat (5) step();
      i_wb_valid = 1'b0;
      i_exp_we   = 1'b0;
      check("pause_commit", int'(o_commit_cnt), 3);
      check("pause_state",  int'(o_state),      1);
      check("pause_err",    int'(o_err_cnt),    0);
      p_i_ce = 1'b1;
      commits(3, 6, -1, -1);
      wait_done(10);
      finish_run();

      // 5: async reset mid-RUN, then restart with retained table
      start();
      commits(0, 2, -1, -1);
      #2;
      p_rst = 1'b1;
      #1;
      check("midrst_state",  int'(o_state),      0);
      check("midrst_commit", int'(o_commit_cnt), 0);
      check("midrst_done",   int'(o_done),       0);
      p_i_ce = 1'b0;
      p_rst  = 1'b0;
      step();
      expect_result(2, 7, 0, 0, 1);
      start();
      commits(0, 6, -1, -1);
      wait_done(10);
      finish_run();

      // 6: last commit on the timeout edge; table write in RUN must be dropped
      expect_result(2, 7, 0, 0, 1);
      start();
      commits(0, 5, -1, -1);
      i_exp_we   = 1'b1;
      i_exp_addr = 3'd0;
      i_exp_pc   = 32'hdead;
      i_exp_data = 32'hbeef;
      step();
      i_exp_we = 1'b0;
      repeat (56) step();
      commits(6, 6, -1, -1);
      wait_done(2);
      finish_run();

      expect_result(2, 7, 0, 0, 1);
      start();
      commits(0, 6, -1, -1);
      wait_done(10);
      finish_run();

      repeat (2) step();
      check("sb_drain", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
